// File: rtl/pipe_mux_pkg.sv
// rtl/pipe_mux_pkg.sv - shared types and limits for the registered N:1 selector
package pipe_mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pm_state_t;

    localparam int PM_MAX_IN = 16;

endpackage

// File: rtl/mux_n_comb.sv
// rtl/mux_n_comb.sv - combinational N:1 select with out-of-range detect
module mux_n_comb #(
    parameter int WIDTH = 64,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      value,
    output logic                  err
);

    // Unmatched codes (only reachable when N_IN is not a power of two) yield zero.
    always_comb begin
        value = '0;
        err   = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                value = data_in[i*WIDTH +: WIDTH];
                err   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_mux_n.sv
// rtl/pipe_mux_n.sv - N:1 selector with registered, stallable two-entry output stage
module pipe_mux_n
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]      sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      data_out,
    output logic                  sel_err
);

    if (N_IN < 2 || N_IN > PM_MAX_IN || SEL_W != $clog2(N_IN)) begin : g_param_check
        $error("pipe_mux_n: N_IN must be 2..16 and SEL_W must equal clog2(N_IN)");
    end

    pm_state_t        state;
    logic [WIDTH-1:0] sel_value;
    logic             sel_bad;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_mux (
        .data_in (data_in),
        .sel     (sel),
        .value   (sel_value),
        .err     (sel_bad)
    );

    // data_out/sel_err are the main register; in_ready and out_valid are
    // registered alongside the state so neither has a combinational input path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            data_out  <= '0;
            sel_err   <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        data_out  <= sel_value;
                        sel_err   <= sel_bad;
                        state     <= BUSY;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        data_out <= sel_value;
                        sel_err  <= sel_bad;
                    end else if (in_valid) begin
                        skid_data <= sel_value;
                        skid_err  <= sel_bad;
                        state     <= FULL;
                        in_ready  <= 1'b0;
                    end else if (out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        data_out <= skid_data;
                        sel_err  <= skid_err;
                        state    <= BUSY;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
